// File: rtl/cdcsync_hs_dst.sv
// Destination side of a toggle-based request/acknowledge CDC handshake.
// src_req is synchronized, each toggle captures src_data once, and des_ack returns a toggle after the consumer accepts.
module cdcsync_hs_dst #(
  parameter int FLOP_N  = 2,
  parameter int DATA_W  = 32,
  parameter int CAP_DLY = 0
) (
  input  logic              des_clk,
  input  logic              des_rst,
  input  logic              src_req,
  input  logic [DATA_W-1:0] src_data,
  output logic              des_ack,
  output logic              des_vld,
  input  logic              des_rdy,
  output logic [DATA_W-1:0] des_data,
  output logic              des_err,
  input  logic              des_err_clr,
  output logic [15:0]       des_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

  localparam logic [3:0] CAP_DLY_W = 4'(CAP_DLY);

  state_t              state_q, state_d;
  logic [FLOP_N-1:0]   sync_q, sync_d;
  logic                req_seen_q, req_seen_d;
  logic [3:0]          dly_q, dly_d;
  logic                vld_q, vld_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                sync_req;
  logic                toggle;

  assign sync_req = sync_q[FLOP_N-1];
  assign toggle   = (sync_req != req_seen_q);

  always_comb begin
    sync_d     = {sync_q[FLOP_N-2:0], src_req};
    state_d    = state_q;
    req_seen_d = req_seen_q;
    dly_d      = dly_q;
    vld_d      = vld_q;
    ack_d      = ack_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (toggle) begin
          req_seen_d = sync_req;
          dly_d      = CAP_DLY_W;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (dly_q != 4'd0) begin
          dly_d = dly_q - 4'd1;
        end else begin
          data_d  = src_data;
          vld_d   = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (vld_q && des_rdy) begin
          vld_d   = 1'b0;
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A toggle while busy means the source did not wait for ack; it is left pending for IDLE to pick up.
    if (des_err_clr) err_d = 1'b0;
    if (toggle && (state_q != IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge des_clk or posedge des_rst) begin
    if (des_rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      req_seen_q <= 1'b0;
      dly_q      <= 4'd0;
      vld_q      <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      req_seen_q <= req_seen_d;
      dly_q      <= dly_d;
      vld_q      <= vld_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign des_ack  = ack_q;
  assign des_vld  = vld_q;
  assign des_data = data_q;
  assign des_err  = err_q;
  assign des_cnt  = cnt_q;

endmodule
